// File: rtl/field_cfg_source.sv
// field_cfg_source
// Buffers an initial cell pattern received over a valid/ready byte stream,
// starts the field configuration loader with a one-cycle go pulse, then
// follows the loader's row-major coordinate scan and turns every scanned
// cell into one registered field-memory write.

module field_cfg_source #(
    parameter int FIELD_W    = 5,
    parameter int FIELD_H    = 3,
    parameter int X_ADR_SIZE = $clog2(FIELD_W),
    parameter int Y_ADR_SIZE = $clog2(FIELD_H)
) (
    input  logic                  clk,
    input  logic                  rst,

    // Pattern byte stream, cells packed LSB first
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,

    // Loader handshake and scan position
    output logic                  o_go,
    input  logic                  i_is_loading,
    input  logic [X_ADR_SIZE-1:0] i_cur_x,
    input  logic [Y_ADR_SIZE-1:0] i_cur_y,

    // Field-memory write port
    output logic                  o_we,
    output logic [X_ADR_SIZE-1:0] o_wx,
    output logic [Y_ADR_SIZE-1:0] o_wy,
    output logic                  o_wdata,
    output logic                  o_done
);

    // ------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------
    localparam int N_CELLS    = FIELD_W * FIELD_H;
    localparam int N_BYTES    = (N_CELLS + 7) / 8;
    // At least one index bit so a single-byte field still has a counter.
    localparam int BYTE_IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    // Buffer depth is rounded up to a power of two so every index value
    // addresses a real entry; entries past N_BYTES are never written.
    localparam int BUF_DEPTH  = 1 << BYTE_IDX_W;
    // Cell number width: byte index plus the 3-bit position in the byte.
    localparam int CELL_W     = BYTE_IDX_W + 3;

    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(N_BYTES - 1);
    localparam logic [CELL_W-1:0]     ROW_PITCH = CELL_W'(FIELD_W);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_GO     = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                  state;
    state_t                  state_next;

    logic [BYTE_IDX_W-1:0]   byte_cnt;
    logic                    byte_fire;
    logic                    last_byte;

    logic                    seen_loading;

    logic [7:0]              pattern_buf [BUF_DEPTH];

    logic [CELL_W-1:0]       cell_n;
    logic [BYTE_IDX_W-1:0]   rd_byte;
    logic [2:0]              rd_bit;
    logic                    cell_bit;

    // ------------------------------------------------------------------
    // Byte intake
    // ------------------------------------------------------------------
    // A byte is consumed only while the block is ready and not in reset,
    // so reset never disturbs the stored pattern.
    assign byte_fire = i_byte_valid && o_byte_ready && !rst;
    assign last_byte = (byte_cnt == LAST_BYTE);

    // Byte counter: walks the buffer during FILL, wraps after the last byte
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= '0;
        end else if (byte_fire) begin
            if (last_byte) begin
                byte_cnt <= '0;
            end else begin
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

    // Pattern storage: written one byte per accepted handshake
    // NOTE: memory arrays get no reset branch; clearing them would turn the
    // RAM into a flop bank, and the pattern must survive reset anyway.
    always_ff @(posedge clk) begin
        if (byte_fire) begin
            pattern_buf[byte_cnt] <= i_byte;
        end
    end

    // ------------------------------------------------------------------
    // Cell lookup for the loader's current coordinate
    // ------------------------------------------------------------------
    // Out-of-field coordinates simply alias into the buffer; the loader
    // never asks for them and their data is don't-care.
    assign cell_n   = CELL_W'(i_cur_y) * ROW_PITCH + CELL_W'(i_cur_x);
    assign rd_byte  = cell_n[CELL_W-1:3];
    assign rd_bit   = cell_n[2:0];
    assign cell_bit = pattern_buf[rd_byte][rd_bit];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register
    // NOTE: every clocked assignment uses <= so all flops update from the
    // same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    // Tracks whether the loader scan has started in the current STREAM visit
    always_ff @(posedge clk) begin
        if (rst) begin
            seen_loading <= 1'b0;
        end else if (state == S_STREAM) begin
            seen_loading <= seen_loading | i_is_loading;
        end else begin
            seen_loading <= 1'b0;
        end
    end

    // Next-state logic
    // NOTE: the default assignment at the top keeps this block purely
    // combinational; any path leaving state_next unassigned would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_FILL: begin
                if (byte_fire && last_byte) begin
                    state_next = S_GO;
                end
            end
            S_GO: begin
                state_next = S_STREAM;
            end
            S_STREAM: begin
                // Leave on the falling edge of the scan, never before it began.
                if (seen_loading && !i_is_loading) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_FILL;
            end
            default: begin
                state_next = S_FILL;
            end
        endcase
    end

    // Output decode: pure functions of the registered state
    always_comb begin
        o_byte_ready = 1'b0;
        o_go         = 1'b0;
        o_done       = 1'b0;
        case (state)
            S_FILL: o_byte_ready = 1'b1;
            S_GO:   o_go         = 1'b1;
            S_DONE: o_done       = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Write port: one-cycle registered copy of the loader scan
    // ------------------------------------------------------------------
    // Registers the scan position and cell value; write enable only in STREAM
    always_ff @(posedge clk) begin
        if (rst) begin
            o_we    <= 1'b0;
            o_wx    <= '0;
            o_wy    <= '0;
            o_wdata <= 1'b0;
        end else if (state == S_STREAM) begin
            o_we    <= i_is_loading;
            o_wx    <= i_cur_x;
            o_wy    <= i_cur_y;
            o_wdata <= cell_bit;
        end else begin
            o_we    <= 1'b0;
        end
    end

endmodule
